// File: rtl/fpga_pkg.sv
// Shared constants, frame field offsets, FSM state type and the CRC-4 step for the 16-node bus demo.
// Latency: n/a (package); backpressure: n/a.
package fpga_pkg;

    localparam int       FRAME_LEN = 84;
    localparam int       NODES     = 16;

    localparam logic [6:0] OFF_SOF  = 7'd0;
    localparam logic [6:0] OFF_SRC  = 7'd1;
    localparam logic [6:0] OFF_DST  = 7'd5;
    localparam logic [6:0] OFF_DATA = 7'd9;
    localparam logic [6:0] OFF_CRC  = 7'd73;
    localparam logic [6:0] OFF_ACK  = 7'd77;
    localparam logic [6:0] OFF_EOF  = 7'd78;
    localparam logic [6:0] LAST_BIT = 7'd83;

    localparam logic [3:0] CRC_POLY = 4'b0011;

    typedef enum logic {
        IDLE = 1'b0,
        TX   = 1'b1
    } state_t;

    function automatic logic [3:0] crc4_step(input logic [3:0] r, input logic d);
        logic fb;
        fb = d ^ r[3];
        return {r[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
    endfunction

endpackage

// File: rtl/fpga_if.sv
// Node-side bus bundle: per-node payload/CRC/destination, request vector and the serial line.
// Latency: none (wires only); backpressure: none.
interface fpga_if;
    logic [3:0]  CRC1,  CRC2,  CRC3,  CRC4,  CRC5,  CRC6,  CRC7,  CRC8;
    logic [3:0]  CRC9,  CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16;
    logic [63:0] Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8;
    logic [63:0] Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16;
    logic [3:0]  receiverAddr1,  receiverAddr2,  receiverAddr3,  receiverAddr4;
    logic [3:0]  receiverAddr5,  receiverAddr6,  receiverAddr7,  receiverAddr8;
    logic [3:0]  receiverAddr9,  receiverAddr10, receiverAddr11, receiverAddr12;
    logic [3:0]  receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16;
    logic [15:0] mod;
    logic        bus_show;

    modport master (
        output CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
               CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
               Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
               Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16,
               receiverAddr1, receiverAddr2, receiverAddr3, receiverAddr4,
               receiverAddr5, receiverAddr6, receiverAddr7, receiverAddr8,
               receiverAddr9, receiverAddr10, receiverAddr11, receiverAddr12,
               receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
               mod,
        input  bus_show
    );

    modport slave (
        input  CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
               CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
               Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
               Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16,
               receiverAddr1, receiverAddr2, receiverAddr3, receiverAddr4,
               receiverAddr5, receiverAddr6, receiverAddr7, receiverAddr8,
               receiverAddr9, receiverAddr10, receiverAddr11, receiverAddr12,
               receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
               mod,
        output bus_show
    );
endinterface

// File: rtl/fpga_crc4_check.sv
// Serial CRC-4 (x^4+x+1) receiver engine, MSB-first, one bit per clock when bit_valid is high.
// Latency: crc reflects a bit one cycle after it is presented; clear wins over bit_valid; no backpressure.
module crc4_check
    import fpga_pkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic [3:0] crc
);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 4'b0000;
        end else if (clear) begin
            crc <= 4'b0000;
        end else if (bit_valid) begin
            crc <= crc4_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/fpga.sv
// 16-node CAN-style bus demo: priority arbitration, frame latch and 84-bit serializer onto bus_show.
// Latency: SOF on the edge that samples a request; frames are contiguous; no backpressure (mod is re-sampled only in IDLE).
module fpga
    import fpga_pkg::*;
(
    input  logic   clock,
    input  logic   rst_n,
    fpga_if.slave  bus
);

    logic [63:0] data_arr [NODES];
    logic [3:0]  crc_arr  [NODES];
    logic [3:0]  addr_arr [NODES];

    assign data_arr[0]  = bus.Data1;   assign crc_arr[0]  = bus.CRC1;   assign addr_arr[0]  = bus.receiverAddr1;
    assign data_arr[1]  = bus.Data2;   assign crc_arr[1]  = bus.CRC2;   assign addr_arr[1]  = bus.receiverAddr2;
    assign data_arr[2]  = bus.Data3;   assign crc_arr[2]  = bus.CRC3;   assign addr_arr[2]  = bus.receiverAddr3;
    assign data_arr[3]  = bus.Data4;   assign crc_arr[3]  = bus.CRC4;   assign addr_arr[3]  = bus.receiverAddr4;
    assign data_arr[4]  = bus.Data5;   assign crc_arr[4]  = bus.CRC5;   assign addr_arr[4]  = bus.receiverAddr5;
    assign data_arr[5]  = bus.Data6;   assign crc_arr[5]  = bus.CRC6;   assign addr_arr[5]  = bus.receiverAddr6;
    assign data_arr[6]  = bus.Data7;   assign crc_arr[6]  = bus.CRC7;   assign addr_arr[6]  = bus.receiverAddr7;
    assign data_arr[7]  = bus.Data8;   assign crc_arr[7]  = bus.CRC8;   assign addr_arr[7]  = bus.receiverAddr8;
    assign data_arr[8]  = bus.Data9;   assign crc_arr[8]  = bus.CRC9;   assign addr_arr[8]  = bus.receiverAddr9;
    assign data_arr[9]  = bus.Data10;  assign crc_arr[9]  = bus.CRC10;  assign addr_arr[9]  = bus.receiverAddr10;
    assign data_arr[10] = bus.Data11;  assign crc_arr[10] = bus.CRC11;  assign addr_arr[10] = bus.receiverAddr11;
    assign data_arr[11] = bus.Data12;  assign crc_arr[11] = bus.CRC12;  assign addr_arr[11] = bus.receiverAddr12;
    assign data_arr[12] = bus.Data13;  assign crc_arr[12] = bus.CRC13;  assign addr_arr[12] = bus.receiverAddr13;
    assign data_arr[13] = bus.Data14;  assign crc_arr[13] = bus.CRC14;  assign addr_arr[13] = bus.receiverAddr14;
    assign data_arr[14] = bus.Data15;  assign crc_arr[14] = bus.CRC15;  assign addr_arr[14] = bus.receiverAddr15;
    assign data_arr[15] = bus.Data16;  assign crc_arr[15] = bus.CRC16;  assign addr_arr[15] = bus.receiverAddr16;

    state_t      state, state_nxt;
    logic [6:0]  cnt, cnt_nxt;
    logic        bus_q, bus_nxt;
    logic        load;
    logic        crc_clear;

    logic [3:0]  win;
    logic [3:0]  lat_src;
    logic [3:0]  lat_dst;
    logic [63:0] lat_data;
    logic [3:0]  lat_crc;

    logic [3:0]  crc_calc;
    logic        ack_bit;
    logic [83:0] frame_vec;
    logic        cur_bit;
    logic        data_phase;

    // Scan downward so the lowest set request index is the last one assigned.
    always_comb begin
        win = 4'd0;
        for (int i = NODES - 1; i >= 0; i--) begin
            if (bus.mod[i]) begin
                win = 4'(i);
            end
        end
    end

    assign ack_bit   = (crc_calc == lat_crc) ? 1'b0 : 1'b1;
    assign frame_vec = {1'b0, lat_src, lat_dst, lat_data, lat_crc, ack_bit, 6'b111111};
    assign cur_bit   = frame_vec[LAST_BIT - cnt];

    assign data_phase = (state == TX) && (cnt >= OFF_DATA) && (cnt < OFF_CRC);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bus_nxt   = bus_q;
        load      = 1'b0;
        crc_clear = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt   = 7'd0;
                bus_nxt   = 1'b1;
                crc_clear = 1'b1;
                if (|bus.mod) begin
                    load      = 1'b1;
                    bus_nxt   = 1'b0;
                    cnt_nxt   = OFF_SRC;
                    state_nxt = TX;
                end
            end
            TX: begin
                bus_nxt = cur_bit;
                if (cnt == LAST_BIT) begin
                    cnt_nxt   = 7'd0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 7'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 7'd0;
                bus_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 7'd0;
            bus_q <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bus_q <= bus_nxt;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            lat_src  <= 4'd0;
            lat_dst  <= 4'd0;
            lat_data <= 64'd0;
            lat_crc  <= 4'd0;
        end else if (load) begin
            lat_src  <= win;
            lat_dst  <= addr_arr[win];
            lat_data <= data_arr[win];
            lat_crc  <= crc_arr[win];
        end
    end

    // The checker sees exactly the data bits as they go onto the line; it settles long before the ACK slot.
    crc4_check u_crc (
        .clock     (clock),
        .rst_n     (rst_n),
        .clear     (crc_clear),
        .bit_valid (data_phase),
        .bit_in    (cur_bit),
        .crc       (crc_calc)
    );

    assign bus.bus_show = bus_q;

endmodule

// File: tb/tb_fpga.sv
// Directed bench for the 16-node bus demo: table of single frames plus back-to-back, arbitration and mid-frame reset sequences.
module tb_fpga;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    fpga_if bus ();

    fpga dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [15:0] mod;
        int          node;
        logic [63:0] d;
        logic [3:0]  c;
        logic [3:0]  a;
        logic [3:0]  src;
        logic        ack;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [83:0] mk(input logic [3:0] src, input logic [3:0] dst,
                                       input logic [63:0] data, input logic [3:0] crc,
                                       input logic ack);
        return {1'b0, src, dst, data, crc, ack, 6'b111111};
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [83:0] act, input logic [83:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_nodes();
        bus.Data1  = '0; bus.CRC1  = '0; bus.receiverAddr1  = '0;
        bus.Data2  = '0; bus.CRC2  = '0; bus.receiverAddr2  = '0;
        bus.Data3  = '0; bus.CRC3  = '0; bus.receiverAddr3  = '0;
        bus.Data4  = '0; bus.CRC4  = '0; bus.receiverAddr4  = '0;
        bus.Data5  = '0; bus.CRC5  = '0; bus.receiverAddr5  = '0;
        bus.Data6  = '0; bus.CRC6  = '0; bus.receiverAddr6  = '0;
        bus.Data7  = '0; bus.CRC7  = '0; bus.receiverAddr7  = '0;
        bus.Data8  = '0; bus.CRC8  = '0; bus.receiverAddr8  = '0;
        bus.Data9  = '0; bus.CRC9  = '0; bus.receiverAddr9  = '0;
        bus.Data10 = '0; bus.CRC10 = '0; bus.receiverAddr10 = '0;
        bus.Data11 = '0; bus.CRC11 = '0; bus.receiverAddr11 = '0;
        bus.Data12 = '0; bus.CRC12 = '0; bus.receiverAddr12 = '0;
        bus.Data13 = '0; bus.CRC13 = '0; bus.receiverAddr13 = '0;
        bus.Data14 = '0; bus.CRC14 = '0; bus.receiverAddr14 = '0;
        bus.Data15 = '0; bus.CRC15 = '0; bus.receiverAddr15 = '0;
        bus.Data16 = '0; bus.CRC16 = '0; bus.receiverAddr16 = '0;
    endtask

    task automatic set_node(input int k, input logic [63:0] d, input logic [3:0] c, input logic [3:0] a);
        case (k)
            1:  begin bus.Data1  = d; bus.CRC1  = c; bus.receiverAddr1  = a; end
            2:  begin bus.Data2  = d; bus.CRC2  = c; bus.receiverAddr2  = a; end
            3:  begin bus.Data3  = d; bus.CRC3  = c; bus.receiverAddr3  = a; end
            9:  begin bus.Data9  = d; bus.CRC9  = c; bus.receiverAddr9  = a; end
            16: begin bus.Data16 = d; bus.CRC16 = c; bus.receiverAddr16 = a; end
            default: ;
        endcase
    endtask

    // Called just after a falling edge with the request already set; samples 84 bits on falling edges.
    task automatic capture(input int change_at, output logic [83:0] f);
        f = '0;
        for (int i = 0; i < 84; i++) begin
            @(negedge clock);
            f[83 - i] = bus.bus_show;
            if (i == change_at) begin
                bus.Data2 = '1;
                bus.CRC2  = 4'hF;
                bus.mod   = 16'h0001;
            end
        end
    endtask

    logic [83:0] f1, f2;

    initial begin
        // CRC of 0...01 is 0011, of 0...010 is 0110, of zero is 0000.
        vecs[0] = '{"node1_crc_bad",  16'h0001, 1,  64'd1, 4'd1, 4'd1, 4'd0,  1'b1};
        vecs[1] = '{"node1_crc_ok",   16'h0001, 1,  64'd1, 4'd3, 4'd1, 4'd0,  1'b0};
        vecs[2] = '{"node1_zero",     16'h0001, 1,  64'd0, 4'd0, 4'd9, 4'd0,  1'b0};
        vecs[3] = '{"node16_crc_ok",  16'h8000, 16, 64'd2, 4'd6, 4'd3, 4'd15, 1'b0};
        vecs[4] = '{"node9_crc_bad",  16'h0100, 9,  64'd2, 4'd5, 4'hC, 4'd8,  1'b1};

        clear_nodes();
        set_node(1, 64'd1, 4'd1, 4'd1);
        bus.mod = 16'h0001;
        rst_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check1("reset_hold", bus.bus_show, 1'b1);
        end
        bus.mod = 16'h0000;
        rst_n   = 1'b1;
        @(negedge clock);
        check1("idle_after_reset", bus.bus_show, 1'b1);

        for (int v = 0; v < 5; v++) begin
            clear_nodes();
            set_node(vecs[v].node, vecs[v].d, vecs[v].c, vecs[v].a);
            bus.mod = vecs[v].mod;
            capture(-1, f1);
            bus.mod = 16'h0000;
            check_frame(vecs[v].name, f1, mk(vecs[v].src, vecs[v].a, vecs[v].d, vecs[v].c, vecs[v].ack));
            check1({vecs[v].name, "_ack"}, f1[6], vecs[v].ack);
            @(negedge clock);
            check1({vecs[v].name, "_idle"}, bus.bus_show, 1'b1);
        end

        // Back-to-back: second request lands during the last bit of the first frame.
        clear_nodes();
        set_node(1, 64'd1, 4'd1, 4'd1);
        bus.mod = 16'h0001;
        capture(-1, f1);
        set_node(2, 64'd0, 4'd1, 4'd2);
        bus.mod = 16'h0002;
        capture(-1, f2);
        bus.mod = 16'h0000;
        check_frame("b2b_first",  f1, mk(4'd0, 4'd1, 64'd1, 4'd1, 1'b1));
        check_frame("b2b_second", f2, mk(4'd1, 4'd2, 64'd0, 4'd1, 1'b1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check1("b2b_idle", bus.bus_show, 1'b1);
        end

        // Arbitration with mid-frame data and request changes.
        clear_nodes();
        set_node(2,  64'd0, 4'd0, 4'd5);
        set_node(3,  64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 4'd7);
        set_node(16, 64'hAAAA_AAAA_AAAA_AAAA, 4'd9, 4'd9);
        bus.mod = 16'h8006;
        capture(20, f1);
        bus.mod = 16'h0000;
        check_frame("arb_node2", f1, mk(4'd1, 4'd5, 64'd0, 4'd0, 1'b0));
        @(negedge clock);
        check1("arb_idle", bus.bus_show, 1'b1);

        // Reset while bit 40 is on the line.
        clear_nodes();
        set_node(1, 64'd1, 4'd3, 4'd4);
        bus.mod = 16'h0001;
        repeat (41) @(negedge clock);
        rst_n = 1'b0;
        #1;
        check1("rst_mid_immediate", bus.bus_show, 1'b1);
        bus.mod = 16'h0000;
        @(negedge clock);
        check1("rst_mid_held", bus.bus_show, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check1("rst_release_idle", bus.bus_show, 1'b1);
        end
        bus.mod = 16'h0001;
        capture(-1, f1);
        bus.mod = 16'h0000;
        check_frame("rst_fresh_frame", f1, mk(4'd0, 4'd4, 64'd1, 4'd3, 1'b0));
        @(negedge clock);
        check1("final_idle", bus.bus_show, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpga.md
Name: fpga

Overview:
- 16-node serial bus model. Each node holds a 64-bit payload, a 4-bit CRC and a 4-bit destination address.
- A one-hot/priority request vector `mod` selects which node transmits a fixed 84-bit CAN-style frame onto the single-bit bus `bus_show`.
- A CRC-4 checker drives the acknowledge slot.
- Top level of the bus demo; no other blocks downstream.

Parameters:
- FRAME_LEN, 84, total bits per frame.
- CRC_POLY, 4'b0011, CRC-4 polynomial x^4+x+1 (x^4 implicit).

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- CRC1..CRC16  in  4 each  CRC transmitted by node k.
- Data1..Data16  in  64 each  payload of node k.
- receiverAddr1..receiverAddr16  in  4 each  destination address sent by node k.
- mod  in  16  transmit request; bit k-1 = node k requests.
- bus_show  out  1  serial bus line, recessive = 1.

Behaviour:
- Reset (async, rst_n=0): bus_show=1, state IDLE, bit counter=0, latched frame cleared. Reset mid-frame aborts the frame immediately; the frame is not resumed.
- Node k has source address k-1 (4 bits; node1=0000, node16=1111).
- States are IDLE and TX.
- IDLE:
  - Each rising edge samples mod.
  - If mod==0: stay IDLE, bus_show=1.
  - Else: arbitration picks the lowest set bit index (node1 highest priority).
  - Winner's Data/CRC/receiverAddr are latched into frame registers, bus_show<=SOF bit (0) on that same edge, counter<=1, go TX.
- Frame layout, bit index 0..83, each field MSB first:
  - 0: SOF=0
  - 1-4: source address
  - 5-8: receiverAddr
  - 9-72: Data[63:0]
  - 73-76: CRC[3:0]
  - 77: ACK
  - 78-83: EOF = six 1s
- One bit per clock; bus_show is registered.
- Inputs are latched at frame start; changes to Data/CRC/addr/mod during TX are ignored.
- ACK bit:
  - Receiver computes CRC-4 serially over the 64 latched data bits, MSB first.
  - CRC register init 0000; per bit: fb = d ^ r[3]; r = {r[2:0],0} ^ (fb ? 4'b0011 : 0).
  - ACK=0 (dominant) when computed CRC == latched CRC field; ACK=1 otherwise.
  - The CRC may be computed during data bits or combinationally from the latched data; only the value output at bit 77 matters.
- After bit 83 (counter==83 on that edge), the next edge re-enters the IDLE evaluation without a gap:
  - If mod!=0 on that edge, the next frame's SOF is output immediately.
  - A frame therefore occupies exactly 84 consecutive cycles, and back-to-back frames are contiguous.
- A request held through frame end re-triggers: mod still asserted produces a repeated frame.
- Multiple bits set in mod: only the lowest-index node transmits; the others are ignored until the next IDLE sampling.
- All widths fixed; no overflow cases beyond the counter, which resets to 0 in IDLE.

Decomposition:
- Shared package `fpga_pkg`:
  - FRAME_LEN=84, field start offsets (SOF=0, SRC=1, DST=5, DATA=9, CRC=73, ACK=77, EOF=78), CRC_POLY, state enum {IDLE, TX}.
- One natural sub-module: `crc4_check`. It is a serial CRC-4 engine taking clock, rst_n, clear, bit_valid and bit_in, and returns crc[3:0].
- Arbitration, latching and serialization stay in the top.

Test Plan:
- Reset: rst_n=0 with mod=1 -> bus_show=1; no frame until rst_n=1.
- Single frame, node1: Data1=1, CRC1=1, receiverAddr1=1, mod=1.
  - Bus sequence: 0, 0000, 0001, 63 zeros then 1, 0001, ACK=1 (computed CRC=0011≠0001), 111111.
  - Exactly 84 cycles.
- Back-to-back, node2: mod changes to 2 at cycle 84 with Data2=0, CRC2=1, receiverAddr2=2.
  - Second frame starts at cycle 84 with no idle bit: 0, 0001, 0010, 64 zeros, 0001, ACK=1, 111111.
  - Then mod=0 -> bus_show stays 1.
- CRC match: Data1=1, CRC1=3, mod=1 -> bit 77 = 0. Data=0, CRC=0 -> ACK=0.
- Arbitration: mod=16'h8006 -> node2 transmits (source 0001); node3 and node16 ignored. Changing Data2 mid-frame does not alter the bits already latched.
- Reset mid-frame: assert rst_n=0 at bit 40 -> bus_show=1 immediately. After release with mod=0, stays 1; with mod=1, a fresh frame starts from SOF.
